// File: rtl/output_stream_unloader_if.sv
// Bundles the memory read port and the output word stream of the
// decoder output unloader.
//   master (unloader side): drives unload_en/unload_addr and
//                           out_data/out_valid/out_last; takes rd_data
//                           and out_ready.
//   slave  (memory + consumer side): the mirror image.
interface output_stream_unloader_if #(
  parameter int unsigned KB           = 14,
  parameter int unsigned HDDW         = 32,
  parameter int unsigned ADDRESSWIDTH = 5
);
  logic                    unload_en;
  logic [ADDRESSWIDTH-1:0] unload_addr;
  logic [KB*HDDW-1:0]      rd_data;
  logic [HDDW-1:0]         out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;

  modport master (
    output unload_en, unload_addr, out_data, out_valid, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  unload_en, unload_addr, out_data, out_valid, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/output_stream_unloader.sv
// Decoder output unloader. A start pulse reads UNLOADCOUNT rows of
// hard-decision data (KB blocks x HDDW bits) from the decoder memory into
// a small row FIFO, and streams them out as HDDW-bit words, block 0 first.
// Read issue is credit based: a row is requested only while the FIFO has
// room for it plus every read still in flight.
// Ports:
//   clk, rst   : single clock, synchronous active-high reset
//   start      : one-cycle unload request (ignored while busy)
//   kb_active  : blocks per row to emit (0 or >KB means KB), taken with start
//   busy       : unload in progress
//   done       : one-cycle pulse after the final word is accepted
//   bus        : memory read port + valid/ready output stream (master)
module output_stream_unloader #(
  parameter int unsigned KB           = 14,
  parameter int unsigned HDDW         = 32,
  parameter int unsigned ADDRESSWIDTH = 5,
  parameter int unsigned UNLOADCOUNT  = 17,
  parameter int unsigned FIFODEPTH    = 4,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned KBW          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KBW-1:0]            kb_active,
  output logic                      busy,
  output logic                      done,
  output_stream_unloader_if.master  bus
);

  localparam int unsigned PW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int unsigned OW = $clog2(FIFODEPTH + 1);
  localparam int unsigned RW = KB * HDDW;
  localparam logic [ADDRESSWIDTH-1:0] LAST_ROW = ADDRESSWIDTH'(UNLOADCOUNT - 1);
  localparam logic [PW-1:0]           LAST_PTR = PW'(FIFODEPTH - 1);
  localparam logic [KBW-1:0]          KB_MAX   = KBW'(KB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [ADDRESSWIDTH-1:0] rows_out_q, rows_out_d;
  logic [KBW-1:0]          kb_eff_q, kb_eff_d;
  logic [KBW-1:0]          w_q, w_d;
  logic [MEM_LATENCY-1:0]  pend_q, pend_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic                    done_q, done_d;
  logic [RW-1:0]           fifo_mem [FIFODEPTH];

  logic                    issue;
  logic                    credit_ok;
  logic                    push;
  logic                    pop;
  logic                    accept;
  logic                    row_end;
  logic                    last_word;
  logic                    fifo_nempty;
  logic [RW-1:0]           head_row;
  logic [HDDW-1:0]         head_word;
  int unsigned             inflight_cnt;

  // Credit: FIFO occupancy plus reads still travelling through the memory
  // pipeline must leave room for one more row.
  always_comb begin
    inflight_cnt = 0;
    for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + {31'b0, pend_q[i]};
    end
    credit_ok = (32'(occ_q) + inflight_cnt) < FIFODEPTH;
  end

  always_comb begin
    fifo_nempty = (occ_q != '0);
    row_end     = (w_q == kb_eff_q - KBW'(1));
    accept      = fifo_nempty && bus.out_ready;
    push        = pend_q[MEM_LATENCY-1];
    pop         = accept && row_end;
    last_word   = fifo_nempty && row_end && (rows_out_q == LAST_ROW);
  end

  always_comb begin
    head_row  = fifo_mem[rd_ptr_q];
    head_word = '0;
    for (int unsigned b = 0; b < KB; b++) begin
      if (w_q == KBW'(b)) begin
        head_word = head_row[b*HDDW +: HDDW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    kb_eff_d  = kb_eff_q;
    issue     = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          kb_eff_d  = ((kb_active == '0) || (kb_active > KB_MAX)) ? KB_MAX : kb_active;
          row_cnt_d = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            row_cnt_d = row_cnt_q + ADDRESSWIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (accept && last_word) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // Truncating the concatenation shifts the new issue flag into slot 0;
    // this form also holds for a single-stage pipeline.
    pend_d = MEM_LATENCY'({pend_q, issue});

    w_d = w_q;
    if (accept) begin
      w_d = row_end ? '0 : w_q + KBW'(1);
    end

    rows_out_d = rows_out_q;
    if (pop) begin
      rows_out_d = (rows_out_q == LAST_ROW) ? '0 : rows_out_q + ADDRESSWIDTH'(1);
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      rows_out_q <= '0;
      kb_eff_q   <= KB_MAX;
      w_q        <= '0;
      pend_q     <= '0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      rows_out_q <= rows_out_d;
      kb_eff_q   <= kb_eff_d;
      w_q        <= w_d;
      pend_q     <= pend_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      done_q     <= done_d;
    end
  end

  // Row storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.rd_data;
    end
  end

  assign bus.unload_en   = issue;
  assign bus.unload_addr = row_cnt_q;
  assign bus.out_valid   = fifo_nempty;
  assign bus.out_data    = fifo_nempty ? head_word : '0;
  assign bus.out_last    = last_word;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;

endmodule

// File: doc/output_stream_unloader.md
Name: output_stream_unloader

Overview:
Parametrised successor to the decoder's output interface. On a start pulse it reads UNLOADCOUNT rows of hard-decision data (KB blocks × HDDW bits each) from the decoder's LLR/HD memory and buffers them in an internal row FIFO. It then streams the rows out as HDDW-bit words over a valid/ready handshake. It runs on a single clock, uses credit-based read issue instead of fixed wait cycles, has a configurable memory read latency, and takes a runtime count of active blocks.

Parameters:
KB, 14, max message blocks per row
HDDW, 32, bits per block word
ADDRESSWIDTH, 5, row address width; UNLOADCOUNT <= 2^ADDRESSWIDTH
UNLOADCOUNT, 17, rows per unload
FIFODEPTH, 4, row-FIFO depth in rows (>=2)
MEM_LATENCY, 2, cycles from unload_en to rd_data valid (>=1)
KBW, 4, width of kb_active (2^KBW > KB)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle unload request (decoder ready)
kb_active  in  KBW  blocks per row to emit; sampled with start
busy  out  1  unload in progress
done  out  1  one-cycle pulse after last word accepted
unload_en  out  1  memory read enable
unload_addr  out  ADDRESSWIDTH  memory row address
rd_data  in  KB*HDDW  row data, valid MEM_LATENCY cycles after unload_en
out_data  out  HDDW  output word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts word
out_last  out  1  marks final word of unload

Behaviour:
- Reset (rst=1 at clk edge) forces busy=0, done=0, unload_en=0, unload_addr=0, out_valid=0, out_last=0, out_data=0. It also clears the FIFO, the in-flight pipeline and all counters. A reset mid-operation discards all data; the memory data already requested is ignored.
- FSM states are IDLE, ISSUE, DRAIN.
- IDLE: start=1 latches kb_eff and moves to ISSUE, with busy=1 from the next cycle. kb_eff = KB if kb_active==0 or kb_active>KB, otherwise kb_active.
- start while busy is ignored.
- ISSUE: each cycle, if occ + inflight < FIFODEPTH, drive unload_en=1 with unload_addr=row_cnt, then increment row_cnt. Otherwise drive unload_en=0.
  - After issuing row UNLOADCOUNT-1, go to DRAIN; unload_addr returns to 0.
- Return path: a MEM_LATENCY-deep valid shift register tracks outstanding reads. inflight is its population count.
  - When a tagged slot exits, rd_data is written into the FIFO at that edge. The FIFO never overflows, by construction of the credit rule.
- Output path: the head row is serialised with word index w from 0 to kb_eff-1, and out_data = head[w*HDDW +: HDDW] (block 0 first).
  - out_valid=1 whenever the FIFO is non-empty.
  - When out_valid && out_ready, w advances. On w==kb_eff-1 the row pops and w resets to 0.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- A simultaneous pop and write in the same cycle is allowed; occ is unchanged.
- out_last=1 on word kb_eff-1 of row UNLOADCOUNT-1.
- DRAIN: when the out_last word is accepted, done=1 for the following cycle and busy=0 from that same cycle. Return to IDLE.
- Latency with out_ready=1: start accepted at cycle 0, first unload_en at cycle 1, first out_valid at cycle MEM_LATENCY+2.
- Steady-state throughput is 1 word/cycle when FIFODEPTH >= ceil((MEM_LATENCY+1)/kb_eff)+1.
- occ width is clog2(FIFODEPTH+1); row_cnt width is ADDRESSWIDTH; no wrap inside an unload.

Test Plan:
1. Defaults, kb_active=14, out_ready=1, rd_data = {row,block} pattern → 238 words in order; out_last only on the 238th word; done pulse 1 cycle later; first out_valid at cycle 4.
2. out_ready=0 after start → exactly 4 unload_en pulses (addresses 0–3), then unload_en stays 0. Releasing ready → resumes at address 4 with no lost or duplicated words.
3. kb_active=3 → 51 words, blocks 0–2 of each row only. kb_active=0 and kb_active=15 → each 238 words.
4. start re-pulsed at cycles 5 and 20 while busy → ignored; exactly one done; total word count unchanged.
5. rst asserted at cycle 30 mid-stream → all outputs 0 next cycle. A fresh start then yields a clean 238-word run beginning at row 0, block 0.
6. Random out_ready (50%) with MEM_LATENCY=4, FIFODEPTH=2 → scoreboard matches, no overflow; out_data stable whenever valid && !ready.
